// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   ctrl_t      : control bundle layout carried between stages (16 bits)
//   stage_e     : identifies a stage boundary (IF/ID .. MEM/WB)
//   ctrl_nop()  : bubble control encoding for a stage boundary
//   *_DEFAULT   : default widths used by pipe_stage_reg
package pipe_pkg;

    localparam int CTRL_W_DEFAULT = 16;
    localparam int CNT_W_DEFAULT  = 16;

    typedef enum logic [1:0] {
        STAGE_IF_ID,
        STAGE_ID_EX,
        STAGE_EX_MEM,
        STAGE_MEM_WB
    } stage_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [5:0] rsvd;
    } ctrl_t;

    // A bubble must never write the register file or memory, so every
    // enable is low; alu_op 0 is a harmless ADD. All boundaries currently
    // share one encoding, but callers select by stage so that can change.
    function automatic ctrl_t ctrl_nop(input stage_e stage);
        ctrl_t nop;
        nop = '0;
        case (stage)
            STAGE_IF_ID,
            STAGE_ID_EX,
            STAGE_EX_MEM,
            STAGE_MEM_WB: nop = '0;
            default:      nop = '0;
        endcase
        return nop;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag + data bundle + control bundle.
//   clk, reset  : clock, asynchronous active-low reset
//   load        : capture d_data/d_ctrl and mark valid
//   clear       : invalidate; ctrl goes to CTRL_NOP, data is held
//   d_data/d_ctrl : entry to capture on load
//   valid/data/ctrl : held entry
// clear has priority over load.
module pipe_slot #(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d_data;
            ctrl_d  = d_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            // NOTE: the data bundle is reset too, so no partial or stale bundle is ever visible after reset.
            data_q  <= '0;
            ctrl_q  <= CTRL_NOP;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign ctrl  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake (in_ready registered when SKID=1)
//   in_data/in_ctrl     : bundles from upstream
//   flush               : kill held and incoming entries at this edge
//   out_valid/out_ready : downstream handshake (out_ready=0 stalls)
//   out_data/out_ctrl   : held bundles; out_ctrl is CTRL_NOP when idle
//   cnt_clr             : clear both counters
//   stall_cnt/drop_cnt  : saturating stall-cycle and flushed-entry counts
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = CTRL_W_DEFAULT,
    parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(ctrl_nop(STAGE_ID_EX)),
    parameter int                SKID     = 1,
    parameter int                CNT_W    = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic              main_load, main_clear;
    logic [DATA_W-1:0] main_d_data;
    logic [CTRL_W-1:0] main_d_ctrl;
    logic              skid_held;
    logic              accept, emit;

    assign accept = in_valid & in_ready;
    assign emit   = main_valid & out_ready;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_data),
        .d_ctrl (main_d_ctrl),
        .valid  (main_valid),
        .data   (main_data),
        .ctrl   (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_valid;
            logic [DATA_W-1:0] skid_data;
            logic [CTRL_W-1:0] skid_ctrl;
            logic              skid_load, skid_clear;

            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)) u_skid (
                .clk    (clk),
                .reset  (reset),
                .load   (skid_load),
                .clear  (skid_clear),
                .d_data (in_data),
                .d_ctrl (in_ctrl),
                .valid  (skid_valid),
                .data   (skid_data),
                .ctrl   (skid_ctrl)
            );

            // MAIN refills from SKID before taking new input, which keeps
            // FIFO order. in_ready only depends on a flop, so it is safe to
            // route a long way back upstream.
            always_comb begin
                main_load   = 1'b0;
                main_clear  = 1'b0;
                main_d_data = in_data;
                main_d_ctrl = in_ctrl;
                skid_load   = 1'b0;
                skid_clear  = 1'b0;
                if (flush) begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end else if (!main_valid || emit) begin
                    if (skid_valid) begin
                        main_load   = 1'b1;
                        main_d_data = skid_data;
                        main_d_ctrl = skid_ctrl;
                        skid_clear  = 1'b1;
                    end else if (accept) begin
                        main_load = 1'b1;
                    end else begin
                        main_clear = 1'b1;
                    end
                end else if (accept) begin
                    skid_load = 1'b1;
                end
            end

            assign in_ready  = ~skid_valid;
            assign skid_held = skid_valid;
        end else begin : g_single
            always_comb begin
                main_load   = 1'b0;
                main_clear  = 1'b0;
                main_d_data = in_data;
                main_d_ctrl = in_ctrl;
                if (flush) begin
                    main_clear = 1'b1;
                end else if (accept) begin
                    main_load = 1'b1;
                end else if (emit) begin
                    main_clear = 1'b1;
                end
            end

            assign in_ready  = ~main_valid | out_ready;
            assign skid_held = 1'b0;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_ctrl;

    // ---------------- counters ----------------
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] drop_q,  drop_d;
    logic [1:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;

    always_comb begin
        // An entry emitted in the flush cycle was consumed downstream and is
        // not a drop; an accept in that cycle is.
        drop_inc = '0;
        if (flush) begin
            drop_inc = 2'(main_valid & ~emit) + 2'(skid_held) + 2'(accept);
        end
        // One extra bit catches overflow so the count pins at all-ones.
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(drop_inc);

        stall_d = stall_q;
        drop_d  = drop_q;
        if (cnt_clr) begin
            stall_d = '0;
            drop_d  = '0;
        end else begin
            if (main_valid && !out_ready && (stall_q != '1)) begin
                stall_d = stall_q + 1'b1;
            end
            drop_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    assign stall_cnt = stall_q;
    assign drop_cnt  = drop_q;

    // An idle stage must always present a bubble downstream.
    a_nop_when_idle: assert property (@(posedge clk) disable iff (!reset)
        !out_valid |-> (out_ctrl == CTRL_NOP));

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int          DW  = 32;
    localparam int          CW  = 8;
    localparam logic [7:0]  NOP = 8'h3C;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // SKID=1, narrow counters
    logic          in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0, cnt_clr = 0;
    logic [DW-1:0] in_data = '0, out_data;
    logic [CW-1:0] in_ctrl = '0, out_ctrl;
    logic [3:0]    stall_cnt, drop_cnt;

    // SKID=0, default counters
    logic          s0_in_valid = 0, s0_in_ready, s0_flush = 0, s0_out_valid, s0_out_ready = 0, s0_cnt_clr = 0;
    logic [DW-1:0] s0_in_data = '0, s0_out_data;
    logic [CW-1:0] s0_in_ctrl = '0, s0_out_ctrl;
    logic [15:0]   s0_stall_cnt, s0_drop_cnt;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(1), .CNT_W(4)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_NOP(NOP), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data), .in_ctrl(s0_in_ctrl),
        .flush(s0_flush),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data), .out_ctrl(s0_out_ctrl),
        .cnt_clr(s0_cnt_clr), .stall_cnt(s0_stall_cnt), .drop_cnt(s0_drop_cnt)
    );

    int errors = 0;
    int n_checks = 0;
    int n_emitted = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctrl_of(input logic [31:0] d);
        return d[7:0] ^ 8'hA5;
    endfunction

    // ---------------- scoreboard on the SKID=1 instance ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  ctrl;
    } ent_t;
    ent_t sb_q[$];

    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
        end else begin
            if (!out_valid) check("idle_ctrl_nop", 32'(out_ctrl), 32'(NOP));
            if (out_valid && out_ready) begin
                n_emitted++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data %0h, expected no entry at %0t", out_data, $time);
                end else begin
                    ent_t e;
                    e = sb_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                end
            end
            if (flush) sb_q.delete();
            else if (in_valid && in_ready) sb_q.push_back('{data: in_data, ctrl: in_ctrl});
        end
    end

    // One clock of stimulus on the SKID=1 instance; acc reports the accept.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic fl, output logic acc);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = ctrl_of(d);
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = in_valid & in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        logic acc;
        cnt_clr = 1'b1;
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        cnt_clr = 1'b0;
        check("cnt_clr_stall", 32'(stall_cnt), 32'h0);
        check("cnt_clr_drop", 32'(drop_cnt), 32'h0);
    endtask

    // ---------------- SKID=0 vector table ----------------
    typedef struct packed {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] d;
        logic        exp_ir;
        logic        exp_ov;
        logic [31:0] exp_d;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl, input logic [31:0] d,
                                input logic exp_ir, input logic exp_ov, input logic [31:0] exp_d);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_d = exp_d;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   next;
        int   emitted_base;
        vec_t vecs[9];

        vecs[0] = mk(1, 1, 0, 32'h11, 1, 1, 32'h11);
        vecs[1] = mk(1, 0, 0, 32'h22, 0, 1, 32'h11);
        vecs[2] = mk(0, 0, 0, 32'h00, 0, 1, 32'h11);
        vecs[3] = mk(1, 1, 0, 32'h33, 1, 1, 32'h33);
        vecs[4] = mk(0, 1, 0, 32'h00, 1, 0, 32'h00);
        vecs[5] = mk(1, 0, 0, 32'h44, 1, 1, 32'h44);
        vecs[6] = mk(1, 0, 1, 32'h55, 0, 0, 32'h00);
        vecs[7] = mk(1, 1, 1, 32'h66, 1, 0, 32'h00);
        vecs[8] = mk(1, 0, 0, 32'h77, 1, 1, 32'h77);

        // ---- 1: reset held with random inputs ----
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; in_ctrl = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
            cnt_clr = 1'($urandom_range(0, 1));
            s0_in_valid = 1'($urandom_range(0, 1)); s0_in_data = $urandom; s0_out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_out_ctrl", 32'(out_ctrl), 32'(NOP));
            check("rst_out_data", out_data, 32'h0);
            check("rst_in_ready", 32'(in_ready), 32'h1);
            check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
            check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
            check("rst0_out_valid", 32'(s0_out_valid), 32'h0);
            check("rst0_in_ready", 32'(s0_in_ready), 32'h1);
        end
        in_valid = 0; out_ready = 0; flush = 0; cnt_clr = 0;
        s0_in_valid = 0; s0_out_ready = 0; s0_in_data = '0;
        reset = 1'b1;

        // ---- 2: stream 1..8, one-cycle latency, no bubbles ----
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 32'(i), 1'b1, 1'b0, acc);
            check("stream_accept", 32'(acc), 32'h1);
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_data", out_data, 32'(i));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("stream_drained", 32'(out_valid), 32'h0);

        // ---- 3: back-pressure into the skid slot ----
        clear_counters();
        emitted_base = n_emitted;
        next = 1;
        for (int c = 1; c <= 12; c++) begin
            cycle(next <= 4, 32'(next), !(c >= 2 && c <= 5), 1'b0, acc);
            if (acc) next++;
            if (c == 3) begin
                check("bp_in_ready", 32'(in_ready), 32'h0);
                check("bp_main_valid", 32'(out_valid), 32'h1);
                check("bp_main_data", out_data, 32'h1);
            end
        end
        check("bp_emitted", 32'(n_emitted - emitted_base), 32'h4);
        check("bp_stall_cnt", 32'(stall_cnt), 32'h4);
        check("bp_sb_empty", 32'(sb_q.size()), 32'h0);

        // ---- 4: flush ----
        clear_counters();
        cycle(1'b1, 32'h101, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h102, 1'b0, 1'b0, acc);
        check("fl_skid_full", 32'(in_ready), 32'h0);
        // Incoming entry is back-pressured (in_ready=0), so only MAIN and SKID count.
        cycle(1'b1, 32'h103, 1'b0, 1'b1, acc);
        check("fl_no_accept", 32'(acc), 32'h0);
        check("fl_out_valid", 32'(out_valid), 32'h0);
        check("fl_out_ctrl", 32'(out_ctrl), 32'(NOP));
        check("fl_in_ready", 32'(in_ready), 32'h1);
        check("fl_drop_cnt", 32'(drop_cnt), 32'h2);
        // Held MAIN plus an accepted incoming entry.
        cycle(1'b1, 32'h104, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h105, 1'b0, 1'b1, acc);
        check("fl2_accept", 32'(acc), 32'h1);
        check("fl2_drop_cnt", 32'(drop_cnt), 32'h4);
        // Emit in the flush cycle is consumed, only the accept is dropped.
        cycle(1'b1, 32'h106, 1'b1, 1'b0, acc);
        cycle(1'b1, 32'h107, 1'b1, 1'b1, acc);
        check("fl3_drop_cnt", 32'(drop_cnt), 32'h5);
        check("fl3_out_valid", 32'(out_valid), 32'h0);

        // ---- 5: counter saturation and clear priority ----
        clear_counters();
        cycle(1'b1, 32'h300, 1'b1, 1'b0, acc);
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'hdead_0000 + 32'(i), 1'b0, 1'b0, acc);
        check("sat_stall_cnt", 32'(stall_cnt), 32'hf);
        check("stall_hold_data", out_data, 32'h300);
        cnt_clr = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        cnt_clr = 1'b0;
        check("clr_over_stall", 32'(stall_cnt), 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
        check("stall_after_clr", 32'(stall_cnt), 32'h1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

        // ---- 6: async reset with MAIN+SKID full ----
        cycle(1'b1, 32'h201, 1'b0, 1'b0, acc);
        cycle(1'b1, 32'h202, 1'b0, 1'b0, acc);
        check("mr_skid_full", 32'(in_ready), 32'h0);
        check("mr_main_full", 32'(out_valid), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'h0);
        check("mr_out_ctrl", 32'(out_ctrl), 32'(NOP));
        check("mr_out_data", out_data, 32'h0);
        check("mr_in_ready", 32'(in_ready), 32'h1);
        check("mr_stall_cnt", 32'(stall_cnt), 32'h0);
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        #2 reset = 1'b1;
        cycle(1'b1, 32'h9, 1'b1, 1'b0, acc);
        check("mr_first_accept", 32'(acc), 32'h1);
        check("mr_data9", out_data, 32'h9);
        cycle(1'b1, 32'hA, 1'b1, 1'b0, acc);
        check("mr_data10", out_data, 32'hA);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
        check("mr_drained", 32'(out_valid), 32'h0);

        // ---- 7: SKID=0 table ----
        for (int k = 0; k < 9; k++) begin
            s0_in_valid  = vecs[k].iv;
            s0_out_ready = vecs[k].ordy;
            s0_flush     = vecs[k].fl;
            s0_in_data   = vecs[k].d;
            s0_in_ctrl   = ctrl_of(vecs[k].d);
            #1;
            check($sformatf("t%0d_in_ready", k), 32'(s0_in_ready), 32'(vecs[k].exp_ir));
            @(posedge clk);
            #1;
            check($sformatf("t%0d_out_valid", k), 32'(s0_out_valid), 32'(vecs[k].exp_ov));
            if (vecs[k].exp_ov) check($sformatf("t%0d_out_data", k), s0_out_data, vecs[k].exp_d);
            check($sformatf("t%0d_out_ctrl", k), 32'(s0_out_ctrl),
                  32'(vecs[k].exp_ov ? ctrl_of(vecs[k].exp_d) : NOP));
        end
        check("t_stall_cnt", 32'(s0_stall_cnt), 32'h3);
        check("t_drop_cnt", 32'(s0_drop_cnt), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
